// File: rtl/accel_pkg.sv
// accel_pkg: state encoding and default datapath widths shared by the PE accumulate/writeback stages
package accel_pkg;
    typedef enum logic [0:0] {ACCUM, DONE} acc_state_t;
    localparam int IN_WIDTH_DEF  = 16;
    localparam int ACC_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_DEF = 10;
endpackage

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: product stream in, accumulated sum out, plus length config and busy status
interface mac_accumulator_if import accel_pkg::*; #(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
    logic [CNT_WIDTH-1:0] cfg_len;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    modport master (
        output cfg_len, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );
    modport slave (
        input  cfg_len, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );
endinterface

// File: rtl/mac_accumulator_reg.sv
// mac_accumulator_reg: write-enabled register building block with asynchronous active-low reset
module mac_accumulator_reg #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         clk,
    input  logic         arst_n_in,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) q <= RST;
        else if (en) q <= d;
    end
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a configurable-length group of signed products and
// holds the result on a valid/ready output until the writeback stage takes it.
module mac_accumulator import accel_pkg::*; #(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input logic              clk,
    input logic              arst_n_in,
    mac_accumulator_if.slave bus
);
    acc_state_t           state, state_d;
    logic [0:0]           state_q;
    logic                 state_en;
    logic [ACC_WIDTH-1:0] acc, acc_d, ext;
    logic [CNT_WIDTH-1:0] cnt, cnt_d, cnt_inc, len_q, cfg_eff, eff_len;
    logic                 accept, first, last;

    assign state = acc_state_t'(state_q);
    assign ext   = ACC_WIDTH'($signed(bus.in_data));

    // The first beat overwrites acc and takes its length straight from cfg_len,
    // so a group never needs a separate clear cycle.
    always_comb begin
        accept  = bus.in_valid && state == ACCUM;
        first   = cnt == '0;
        cfg_eff = bus.cfg_len == '0 ? CNT_WIDTH'(1) : bus.cfg_len;
        eff_len = first ? cfg_eff : len_q;
        cnt_inc = cnt + CNT_WIDTH'(1);
        last    = cnt_inc == eff_len;
        cnt_d   = last ? '0 : cnt_inc;
        acc_d   = first ? ext : acc + ext;
    end

    always_comb begin
        state_d  = state;
        state_en = 1'b0;
        state_d  = state == ACCUM ? DONE : ACCUM;
        state_en = state == ACCUM ? accept && last : bus.out_ready;
    end

    mac_accumulator_reg #(.W(1), .RST(1'(ACCUM))) u_state (
        .clk(clk), .arst_n_in(arst_n_in), .en(state_en), .d(state_d), .q(state_q)
    );
    mac_accumulator_reg #(.W(ACC_WIDTH)) u_acc (
        .clk(clk), .arst_n_in(arst_n_in), .en(accept), .d(acc_d), .q(acc)
    );
    mac_accumulator_reg #(.W(CNT_WIDTH)) u_cnt (
        .clk(clk), .arst_n_in(arst_n_in), .en(accept), .d(cnt_d), .q(cnt)
    );
    mac_accumulator_reg #(.W(CNT_WIDTH)) u_len (
        .clk(clk), .arst_n_in(arst_n_in), .en(accept && first), .d(cfg_eff), .q(len_q)
    );

    assign bus.in_ready  = state == ACCUM;
    assign bus.out_valid = state == DONE;
    assign bus.out_data  = acc;
    assign bus.busy      = state == DONE || cnt != '0;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: vector table, corner-case sequences and a randomized
// group-sum reference model for mac_accumulator (32-bit and 16-bit accumulators).
module tb_mac_accumulator;
    logic clk = 1'b0;
    logic arst_n_in = 1'b0;
    always #5 clk = ~clk;

    mac_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(10)) bus();
    mac_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(10)) bus16();

    assign bus16.cfg_len   = bus.cfg_len;
    assign bus16.in_data   = bus.in_data;
    assign bus16.in_valid  = bus.in_valid;
    assign bus16.out_ready = bus.out_ready;

    mac_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(10)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .bus(bus)
    );
    mac_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(10)) dut16 (
        .clk(clk), .arst_n_in(arst_n_in), .bus(bus16)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int len;
        int n;
        int d[6];
        int exp;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] u32(input int v);
        return {32'h0, v[31:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mk(input int i, input int len, input int n, input int exp,
                      input int a, input int b, input int c, input int d, input int e, input int f);
        vecs[i].len = len;
        vecs[i].n   = n;
        vecs[i].exp = exp;
        vecs[i].d[0] = a; vecs[i].d[1] = b; vecs[i].d[2] = c;
        vecs[i].d[3] = d; vecs[i].d[4] = e; vecs[i].d[5] = f;
    endtask

    task automatic beat(input int len, input int v);
        bus.cfg_len  = 10'(len);
        bus.in_data  = 16'(v);
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int L, eff, gap, hold;
        logic [31:0] r;
        longint sum;
        logic [63:0] sumv;
        bus.cfg_len = '0; bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        mk(0, 4, 4, 105, 3, -5, 7, 100, 0, 0);
        mk(1, 0, 1, -7, -7, 0, 0, 0, 0, 0);
        mk(2, 1, 1, -7, -7, 0, 0, 0, 0, 0);
        mk(3, 3, 3, -65537, -32768, -32768, -1, 0, 0, 0);
        mk(4, 6, 6, 2500, 1000, 2000, -500, 32767, -32768, 1);
        tick; tick;
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_in_ready", 64'(bus.in_ready), 1);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_out_data", 64'(bus.out_data), 0);
        arst_n_in = 1'b1;
        tick;

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                bus.cfg_len = 10'(vecs[i].len);
                bus.in_data = 16'(vecs[i].d[j]);
                bus.in_valid = 1'b1;
                tick;
            end
            bus.in_valid = 1'b0;
            chk("vec_out_valid", 64'(bus.out_valid), 1);
            chk("vec_out_data", 64'(bus.out_data), u32(vecs[i].exp));
            chk("vec_in_ready_done", 64'(bus.in_ready), 0);
            tick;
            chk("vec_out_valid_after", 64'(bus.out_valid), 0);
            chk("vec_in_ready_after", 64'(bus.in_ready), 1);
            chk("vec_busy_after", 64'(bus.busy), 0);
        end

        beat(2, 32'h7FFF);
        chk("wrap_busy_mid", 64'(bus.busy), 1);
        beat(2, 32'h7FFF);
        chk("wrap16_out_data", 64'(bus16.out_data), 64'hFFFE);
        chk("wrap32_out_data", 64'(bus.out_data), 64'hFFFE);
        tick;

        bus.out_ready = 1'b0;
        beat(3, 1); beat(3, 2); beat(3, 3);
        for (int k = 0; k < 10; k++) begin
            r = $urandom;
            bus.in_valid = k[0];
            bus.in_data = r[15:0];
            tick;
            chk("stall_out_valid", 64'(bus.out_valid), 1);
            chk("stall_out_data", 64'(bus.out_data), 6);
            chk("stall_in_ready", 64'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        chk("stall_release", 64'(bus.out_valid), 0);
        beat(1, 9);
        chk("post_stall_sum", 64'(bus.out_data), 9);
        tick;

        beat(5, 1);
        beat(2, 2);
        chk("cfg_change_no_early", 64'(bus.out_valid), 0);
        beat(2, 3); beat(2, 4); beat(2, 5);
        chk("cfg_change_valid", 64'(bus.out_valid), 1);
        chk("cfg_change_sum", 64'(bus.out_data), 15);
        tick;
        beat(2, 10); beat(2, 20);
        chk("cfg_next_valid", 64'(bus.out_valid), 1);
        chk("cfg_next_sum", 64'(bus.out_data), 30);
        tick;

        beat(4, 50); beat(4, 60);
        #2 arst_n_in = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 0);
        chk("arst_in_ready", 64'(bus.in_ready), 1);
        chk("arst_busy", 64'(bus.busy), 0);
        chk("arst_out_data", 64'(bus.out_data), 0);
        arst_n_in = 1'b1;
        tick;
        beat(4, 1); beat(4, 1); beat(4, 1);
        chk("arst_no_early", 64'(bus.out_valid), 0);
        beat(4, 1);
        chk("arst_next_sum", 64'(bus.out_data), 4);
        tick;

        // Random groups: the expected sum is simply the first effective-length
        // accepted products, regardless of cfg_len wiggling mid-group.
        for (int g = 0; g < 40; g++) begin
            L = $urandom_range(0, 8);
            eff = (L == 0) ? 1 : L;
            sum = 0;
            for (int j = 0; j < eff; j++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    bus.in_valid = 1'b0;
                    bus.cfg_len = 10'($urandom);
                    tick;
                end
                r = $urandom;
                bus.in_valid = 1'b1;
                bus.in_data = r[15:0];
                bus.cfg_len = (j == 0) ? 10'(L) : 10'($urandom);
                sum += longint'($signed(r[15:0]));
                bus.out_ready = 1'b0;
                tick;
            end
            bus.in_valid = 1'b0;
            sumv = sum;
            chk("rnd_latency", 64'(bus.out_valid), 1);
            hold = $urandom_range(0, 3);
            repeat (hold) tick;
            chk("rnd_hold_valid", 64'(bus.out_valid), 1);
            chk("rnd_sum32", 64'(bus.out_data), {32'h0, sumv[31:0]});
            chk("rnd_sum16", 64'(bus16.out_data), {48'h0, sumv[15:0]});
            bus.out_ready = 1'b1;
            tick;
            bus.out_ready = 1'b0;
            chk("rnd_consumed", 64'(bus.out_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
